// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response and preload signals between fetch stage (master) and instruction memory (slave)
interface imem_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_BITS  = 10
);
  logic [DATA_WIDTH-1:0] req_addr;
  logic [ID_WIDTH-1:0]   req_id;
  logic                  req_valid;
  logic                  stall;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [ID_WIDTH-1:0]   resp_id;
  logic                  resp_valid;
  logic                  load_en;
  logic [ADDR_BITS-1:0]  load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  modport master (
    output req_addr, req_id, req_valid, load_en, load_addr, load_data,
    input  stall, resp_data, resp_id, resp_valid
  );
  modport slave (
    input  req_addr, req_id, req_valid, load_en, load_addr, load_data,
    output stall, resp_data, resp_id, resp_valid
  );
endinterface

// File: rtl/imem_responder.sv
// imem_responder: in-order tagged fetch responder with fixed latency; define IMEM_RAND_LAT_EN for LFSR-driven extra latency
module imem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_BITS  = 10,
  parameter int LATENCY    = 3,
  parameter int QDEPTH     = 4
) (
  input logic clk,
  input logic reset,
  imem_responder_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(LATENCY + 2);
  localparam logic [PW:0] FULL = QDEPTH[PW:0];
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt, lat_load;
  logic [PW:0] count;
  logic [PW-1:0] rd, wr;
  logic [ADDR_BITS-1:0] q_idx [QDEPTH];
  logic [ID_WIDTH-1:0] q_id [QDEPTH];
  logic [ADDR_BITS-1:0] svc_idx;
  logic [ID_WIDTH-1:0] svc_id;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];
  logic push, pop, done, unused_addr;
  assign bus.stall = (count == FULL) | bus.load_en;
  assign push = bus.req_valid & ~bus.stall;
  assign done = state == BUSY && cnt == '0;
  assign pop = count != '0 && (state == IDLE || done);
  assign unused_addr = ^{bus.req_addr[DATA_WIDTH-1:ADDR_BITS+2], bus.req_addr[1:0]};
`ifdef IMEM_RAND_LAT_EN
  logic [7:0] lfsr;
  assign lat_load = CW'(LATENCY - 2) + CW'(lfsr[1:0]);
`else
  assign lat_load = CW'(LATENCY - 2);
`endif
  // array and queue storage are deliberately left out of reset
  always_ff @(posedge clk) begin
    if (bus.load_en) mem[bus.load_addr] <= bus.load_data;
    if (push) begin
      q_idx[wr] <= bus.req_addr[ADDR_BITS+1:2];
      q_id[wr] <= bus.req_id;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      count <= '0;
      rd <= '0;
      wr <= '0;
      svc_idx <= '0;
      svc_id <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data <= '0;
      bus.resp_id <= '0;
`ifdef IMEM_RAND_LAT_EN
      lfsr <= 8'hA5;
`endif
    end else begin
      bus.resp_valid <= done;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (push) wr <= wr + 1'b1;
      if (done) begin
        bus.resp_data <= mem[svc_idx];
        bus.resp_id <= svc_id;
      end
      if (pop) begin
        svc_idx <= q_idx[rd];
        svc_id <= q_id[rd];
        rd <= rd + 1'b1;
        cnt <= lat_load;
        state <= BUSY;
`ifdef IMEM_RAND_LAT_EN
        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`endif
      end else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
      else if (done) state <= IDLE;
    end
  end
endmodule
